cntreg_timer: RTL and testbench
===============================

// Module: cntreg_timer
// PURPOSE
//  Parametrised counter/timer register, next generation of the plain load/increment counter.
//  Adds up/down counting, a programmable limit with auto-reload, a compare register, and flag outputs.
//  Sits on the peripheral side of the CPU bus as a timer/event counter; all registers are bus-writable.
//  Optional clock-enable prescaler.
// PARAMETERS
//  WIDTH     32          counter, limit and compare width
//  PSC_WIDTH 8           prescaler width (used only with CNTREG_TIMER_PRESCALER_EN)
//  RST_LIM   {WIDTH{1}}  reset value of limit register
// PORTS
//  clk       in   1          clock, all state changes on posedge
//  reset     in   1          synchronous, active-high reset
//  cen       in   1          count enable (one tick per cycle high)
//  wen       in   1          load counter from din
//  din       in   WIDTH      counter load data
//  dir       in   1          0 = count up, 1 = count down
//  autorl    in   1          1 = wrap at limit/0 (reload mode), 0 = free-run mod 2^WIDTH
//  lim_wen   in   1          write limit register from din
//  cmp_wen   in   1          write compare register from din
//  psc_wen   in   1          write prescaler register from din[PSC_WIDTH-1:0]
//  flag_clr  in   1          clear ovf and match
//  dout      out  WIDTH      counter value
//  lim_q     out  WIDTH      limit register
//  cmp_q     out  WIDTH      compare register
//  tc        out  1          terminal-count pulse, one cycle
//  ovf       out  1          sticky wrap flag
//  match     out  1          sticky compare flag
// BEHAVIOUR
//  Reset: dout=0, lim_q=RST_LIM, cmp_q=0, tc=0, ovf=0, match=0; prescaler count=0, psc reg=0.
//  Reset overrides every other input, including mid-count.
//  Tick = cen qualified by the prescaler (see CONFIGURATION); without prescaler, tick = cen.
//  Counter update priority: tick > wen (tick in the same cycle drops the load), else hold.
//  Up tick:
//   - autorl=1 and dout==lim_q -> 0 (wrap).
//   - autorl=0 and dout=={WIDTH{1}} -> 0 (wrap).
//   - otherwise dout+1.
//  Down tick:
//   - dout==0 -> lim_q if autorl=1, else {WIDTH{1}} (wrap).
//   - otherwise dout-1.
//  Up tick with autorl=1 and dout>lim_q: increment continues; wraps only at {WIDTH{1}}, and that wrap counts.
//  All arithmetic is modulo 2^WIDTH; no carry is kept.
//  tc: registered, high for exactly the cycle after a wrap tick. Back-to-back wraps give consecutive tc pulses.
//  ovf: set on every wrap tick and stays set until flag_clr. Set wins over flag_clr in the same cycle.
//  match: set when the counter's next value (tick or wen load) equals cmp_q. Set wins over clear; sticky.
//   - A cmp_wen write does not evaluate match against the current dout.
//  lim_wen, cmp_wen, psc_wen: take effect next cycle, independent of tick and wen.
//   - A tick in the same cycle as a register write uses the old register value.
//  All outputs are registered; write-to-dout latency is 1 cycle.
// CONFIGURATION
//  CNTREG_TIMER_PRESCALER_EN defined:
//   - PSC_WIDTH register psc (psc_wen) and counter pc.
//   - On cen: if pc==psc then pc<=0 and tick, else pc<=pc+1.
//   - psc=0 gives a tick on every cen.
//   - wen clears pc; psc_wen clears pc.
//  Not defined: psc_wen is ignored, no prescaler state, tick = cen.
// TESTING
//  1. reset, cen=1, dir=0, autorl=0, 5 cycles -> dout=5; tc=ovf=match=0.
//  2. lim=3, autorl=1, up: dout 0,1,2,3,0 -> tc=1 only the cycle after 3->0; ovf set; flag_clr -> ovf=0.
//  3. dir=1, autorl=0, load din=1, cen: dout 1,0,FFFFFFFF -> ovf=1.
//     Same with autorl=1, lim=9 -> dout 1,0,9.
//  4. cmp=7, up from 5 -> match rises the cycle dout becomes 7.
//     flag_clr and a 7-hit in the same cycle -> match stays 1.
//  5. cen=1 and wen=1 with din=100, dout=10 -> dout=11 (tick wins).
//     Reset asserted mid-count -> all outputs at reset values next cycle.
//  6. (PRESCALER_EN) psc=2, cen held high -> dout increments every 3rd cycle.
//     psc_wen mid-count -> pc restarts from 0.

Source files
------------

// File: rtl/cntreg_timer.sv
// cntreg_timer: counter/timer register with up/down counting, a programmable
// limit with auto-reload, a compare register and sticky flags.
// Optional clock-enable prescaler, built when CNTREG_TIMER_PRESCALER_EN is defined.
module cntreg_timer #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      PSC_WIDTH = 8,
   parameter logic [WIDTH-1:0] RST_LIM   = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cen,
   input  logic             wen,
   input  logic [WIDTH-1:0] din,
   input  logic             dir,
   input  logic             autorl,
   input  logic             lim_wen,
   input  logic             cmp_wen,
   input  logic             psc_wen,
   input  logic             flag_clr,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] lim_q,
   output logic [WIDTH-1:0] cmp_q,
   output logic             tc,
   output logic             ovf,
   output logic             match
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] lim;
   logic [WIDTH-1:0] cmp;
   logic [WIDTH-1:0] cnt_nxt;
   logic             tick;
   logic             wrap;
   logic             upd;
   logic             tc_r;
   logic             ovf_r;
   logic             match_r;

`ifdef CNTREG_TIMER_PRESCALER_EN
   logic [PSC_WIDTH-1:0] psc;
   logic [PSC_WIDTH-1:0] pc;

   assign tick = cen && (pc == psc);

   // Prescaler: divide cen by psc+1; counter load or divider write restarts it
   always_ff @(posedge clk) begin
      if (reset) begin
         psc <= '0;
         pc  <= '0;
      end else begin
         if (psc_wen) begin
            psc <= din[PSC_WIDTH-1:0];
         end
         if (wen || psc_wen) begin
            pc <= '0;
         end else if (cen) begin
            pc <= (pc == psc) ? '0 : pc + 1'b1;
         end
      end
   end
`else
   logic [PSC_WIDTH-1:0] unused_psc;

   assign unused_psc = {PSC_WIDTH{psc_wen}};
   assign tick       = cen;
`endif

   assign upd = tick || wen;

   // Next counter value: tick beats load; wrap detection for up and down
   always_comb begin
      cnt_nxt = cnt;
      wrap    = 1'b0;
      if (tick) begin
         if (!dir) begin
            // Above the limit in reload mode the count runs on to all-ones
            if ((autorl && (cnt == lim)) || (cnt == '1)) begin
               cnt_nxt = '0;
               wrap    = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end else begin
            if (cnt == '0) begin
               cnt_nxt = autorl ? lim : '1;
               wrap    = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
      end else if (wen) begin
         cnt_nxt = din;
      end
   end

   // Counter, configuration registers and flags
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         lim     <= RST_LIM;
         cmp     <= '0;
         tc_r    <= 1'b0;
         ovf_r   <= 1'b0;
         match_r <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         tc_r <= wrap;
         if (lim_wen) begin
            lim <= din;
         end
         if (cmp_wen) begin
            cmp <= din;
         end
         if (wrap) begin
            ovf_r <= 1'b1;
         end else if (flag_clr) begin
            ovf_r <= 1'b0;
         end
         // Match compares the value being written into the counter against
         // the compare value in force this cycle
         if (upd && (cnt_nxt == cmp)) begin
            match_r <= 1'b1;
         end else if (flag_clr) begin
            match_r <= 1'b0;
         end
      end
   end

   assign dout  = cnt;
   assign lim_q = lim;
   assign cmp_q = cmp;
   assign tc    = tc_r;
   assign ovf   = ovf_r;
   assign match = match_r;

endmodule

// File: tb/tb_cntreg_timer.sv
// tb_cntreg_timer: directed test of cntreg_timer against a behavioural model,
// with per-cycle comparison and hand-computed spot checks.
module tb_cntreg_timer;

   localparam longint MOD  = 64'h1_0000_0000;
   localparam longint MAXV = MOD - 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        cen, wen, dir, autorl, lim_wen, cmp_wen, psc_wen, flag_clr;
   logic [31:0] din;
   logic [31:0] dout, lim_q, cmp_q;
   logic        tc, ovf, match;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   longint m_cnt, m_lim, m_cmp, m_pc, m_psc;
   bit     m_tc, m_ovf, m_match;

   cntreg_timer dut (
      .clk(clk), .reset(reset), .cen(cen), .wen(wen), .din(din), .dir(dir),
      .autorl(autorl), .lim_wen(lim_wen), .cmp_wen(cmp_wen), .psc_wen(psc_wen),
      .flag_clr(flag_clr), .dout(dout), .lim_q(lim_q), .cmp_q(cmp_q),
      .tc(tc), .ovf(ovf), .match(match)
   );

   always #5 clk = ~clk;

   // Behavioural model, advanced on each rising edge
   always @(posedge clk) begin
      longint n;
      bit     tk, moved, wrapped;
      if (reset) begin
         m_cnt = 0; m_lim = MAXV; m_cmp = 0; m_pc = 0; m_psc = 0;
         m_tc = 0; m_ovf = 0; m_match = 0;
      end else begin
`ifdef CNTREG_TIMER_PRESCALER_EN
         tk = cen && (m_pc == m_psc);
`else
         tk = cen;
`endif
         n = m_cnt; moved = 0; wrapped = 0;
         if (tk) begin
            moved = 1;
            if (!dir) begin
               n = (autorl && m_cnt == m_lim) ? 0 : (m_cnt + 1) % MOD;
               wrapped = (n == 0);
            end else begin
               wrapped = (m_cnt == 0);
               n = wrapped ? (autorl ? m_lim : MAXV) : m_cnt - 1;
            end
         end else if (wen) begin
            moved = 1;
            n = din;
         end
         m_match = (moved && n == m_cmp) ? 1'b1 : (flag_clr ? 1'b0 : m_match);
         m_ovf   = wrapped ? 1'b1 : (flag_clr ? 1'b0 : m_ovf);
         m_tc    = wrapped;
         if (lim_wen) m_lim = din;
         if (cmp_wen) m_cmp = din;
`ifdef CNTREG_TIMER_PRESCALER_EN
         if (wen || psc_wen) m_pc = 0;
         else if (cen) m_pc = tk ? 0 : (m_pc + 1) % 256;
         if (psc_wen) m_psc = din % 256;
`endif
         m_cnt = n;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (dout !== 32'(m_cnt) || lim_q !== 32'(m_lim) || cmp_q !== 32'(m_cmp) ||
             tc !== m_tc || ovf !== m_ovf || match !== m_match) begin
            errors++;
            $display("FAIL model t=%0t got dout=%0h lim=%0h cmp=%0h tc=%b ovf=%b match=%b want dout=%0h lim=%0h cmp=%0h tc=%b ovf=%b match=%b",
                     $time, dout, lim_q, cmp_q, tc, ovf, match,
                     m_cnt, m_lim, m_cmp, m_tc, m_ovf, m_match);
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle();
      cen = 0; wen = 0; lim_wen = 0; cmp_wen = 0; psc_wen = 0; flag_clr = 0;
   endtask

   initial begin
      idle();
      dir = 0; autorl = 0; din = '0; reset = 1;
      step(1);
      chk_en = 1;
      chk("rst_dout", dout, 0);
      chk("rst_lim", lim_q, MAXV);
      chk("rst_flags", {tc, ovf, match}, 0);

      // 1: free-run up
      reset = 0; cen = 1;
      step(5);
      chk("up5_dout", dout, 5);
      chk("up5_flags", {tc, ovf, match}, 0);

      // 2: limit 3 with reload
      idle(); lim_wen = 1; din = 3; step(1);
      idle(); wen = 1; din = 0; step(1);
      chk("lim3_lim", lim_q, 3);
      idle(); autorl = 1; cen = 1;
      step(1); chk("rl_1", dout, 1);
      step(1); chk("rl_2", dout, 2);
      step(1); chk("rl_3", dout, 3); chk("rl_3_tc", tc, 0);
      step(1); chk("rl_0", dout, 0); chk("rl_0_tc", tc, 1); chk("rl_0_ovf", ovf, 1);
      idle(); step(1); chk("rl_tc_off", tc, 0); chk("rl_ovf_held", ovf, 1);
      flag_clr = 1; step(1); chk("ovf_clr", ovf, 0);

      // 3: down count, free-run then reload
      idle(); dir = 1; autorl = 0; wen = 1; din = 1; flag_clr = 1; step(1);
      chk("dn_load", dout, 1);
      idle(); cen = 1;
      step(1); chk("dn_0", dout, 0);
      step(1); chk("dn_wrap", dout, MAXV); chk("dn_wrap_ovf", ovf, 1); chk("dn_wrap_tc", tc, 1);
      idle(); autorl = 1; lim_wen = 1; din = 9; step(1);
      idle(); wen = 1; din = 1; flag_clr = 1; step(1);
      idle(); cen = 1;
      step(1); chk("dnrl_0", dout, 0);
      step(1); chk("dnrl_lim", dout, 9); chk("dnrl_ovf", ovf, 1);

      // 4: compare flag
      idle(); dir = 0; autorl = 0; cmp_wen = 1; din = 7; step(1);
      idle(); wen = 1; din = 5; flag_clr = 1; step(1);
      chk("cmp_pre", match, 0);
      idle(); cen = 1;
      step(1); chk("cmp_6", match, 0);
      step(1); chk("cmp_7_dout", dout, 7); chk("cmp_7", match, 1);
      idle(); wen = 1; din = 6; flag_clr = 1; step(1); chk("cmp_cleared", match, 0);
      idle(); cen = 1; flag_clr = 1; step(1); chk("cmp_set_wins", match, 1);
      idle(); flag_clr = 1; cmp_wen = 1; din = 9; step(1); chk("cmp_clr2", match, 0);
      idle(); cmp_wen = 1; din = 7; step(1);
      chk("cmp_write_no_eval", match, 0); chk("cmp_q7", cmp_q, 7);

      // 5: tick beats load, reset mid-count
      idle(); wen = 1; din = 10; step(1);
      idle(); cen = 1; wen = 1; din = 100; step(1); chk("tick_wins", dout, 11);
      idle(); cen = 1; step(2); chk("run_13", dout, 13);
      reset = 1; lim_wen = 1; din = 5; step(1);
      chk("mid_rst_dout", dout, 0); chk("mid_rst_lim", lim_q, MAXV);
      chk("mid_rst_cmp", cmp_q, 0); chk("mid_rst_flags", {tc, ovf, match}, 0);
      reset = 0; idle();

      // Register write in the same cycle as a wrap uses the old limit
      autorl = 1; lim_wen = 1; din = 3; step(1);
      idle(); wen = 1; din = 3; step(1);
      idle(); cen = 1; lim_wen = 1; din = 10; step(1);
      chk("old_lim_wrap", dout, 0); chk("old_lim_tc", tc, 1); chk("new_lim", lim_q, 10);

      // Above the limit in reload mode: runs to all-ones, then wraps
      idle(); lim_wen = 1; din = 3; step(1);
      idle(); wen = 1; din = 32'hFFFF_FFFE; step(1);
      idle(); cen = 1;
      step(1); chk("above_max", dout, MAXV); chk("above_tc0", tc, 0);
      step(1); chk("above_wrap", dout, 0); chk("above_tc1", tc, 1);

      // Back-to-back wraps with limit 0
      idle(); lim_wen = 1; din = 0; step(1);
      idle(); cen = 1;
      step(1); chk("b2b_tc1", tc, 1);
      step(1); chk("b2b_tc2", tc, 1);

`ifdef CNTREG_TIMER_PRESCALER_EN
      // 6: prescaler divide by 3, restart on divider write
      idle(); autorl = 0; dir = 0; psc_wen = 1; din = 2; step(1);
      idle(); wen = 1; din = 0; step(1);
      idle(); cen = 1;
      step(2); chk("psc_hold", dout, 0);
      step(1); chk("psc_t1", dout, 1);
      step(3); chk("psc_t2", dout, 2);
      step(1);
      psc_wen = 1; din = 2; step(1);
      idle(); cen = 1;
      step(2); chk("psc_restart_hold", dout, 2);
      step(1); chk("psc_restart_tick", dout, 3);
`endif

      idle();
      step(1);
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
